// File: rtl/sudoku_mask_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sudoku_mask_iter
//  Purpose  : Iteration controller around the combinational sudoku
//             mask-elimination chain. Loads a 729-bit candidate mask, feeds
//             the registered mask to the chain and writes the chain's result
//             back every cycle until a fixed point, a contradiction or
//             MAX_ITER passes. It then classifies the final mask: solved,
//             contradiction or timeout. It also reports the pass count and
//             the decoded 81-cell grid.
//  Ports    : clk            - rising-edge clock
//             reset          - synchronous, active-high
//             i_in_valid     - initial mask on i_mask_in is valid
//             o_in_ready     - idle, a mask will be accepted
//             i_mask_in      - initial mask, bit x*81+y*9+v = digit v+1
//                              excluded at cell (x,y)
//             o_stg_mask_out - registered mask driven into the chain
//             i_stg_mask_in  - chain result for o_stg_mask_out (same cycle)
//             o_done         - one-cycle pulse, results valid from here on
//             o_solved       - every cell has exactly one candidate
//             o_contradict   - some cell has no candidate
//             o_timeout      - stopped on MAX_ITER with no fixed point
//                              and no contradiction
//             o_iter_count   - number of passes taken
//             o_grid         - cell (x,y) at [(x*9+y)*4 +: 4], 1..9 or 0
//  Revision : 1.0 - initial release
// ============================================================================
module sudoku_mask_iter #(
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [728:0]      i_mask_in,
  output logic [728:0]      o_stg_mask_out,
  input  logic [728:0]      i_stg_mask_in,
  output logic              o_done,
  output logic              o_solved,
  output logic              o_contradict,
  output logic              o_timeout,
  output logic [ITER_W-1:0] o_iter_count,
  output logic [323:0]      o_grid
);

  localparam int c_CELLS = 81;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ITER  = 2'd1;
  localparam logic [1:0] c_CHECK = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [ITER_W-1:0] c_ITER_ONE  = ITER_W'(1);
  localparam logic [ITER_W-1:0] c_LAST_ITER = ITER_W'(MAX_ITER - 1);

  logic [1:0]        r_state;
  logic [728:0]      r_mask;
  logic [ITER_W-1:0] r_iter_cnt;
  logic              r_solved;
  logic              r_contradict;
  logic              r_timeout;
  logic [ITER_W-1:0] r_iter_count;
  logic [323:0]      r_grid;

  logic              w_fixed;
  logic              w_bad;
  logic [80:0]       w_cell_full;    // chain result: cell has all 9 exclusions
  logic [80:0]       w_cell_single;  // registered mask: exactly one candidate
  logic [80:0]       w_cell_empty;   // registered mask: no candidate left
  logic [323:0]      w_grid;

  // Per-cell decode. The "full" test looks at the chain result so a
  // contradiction stops iteration in the same pass that produces it; the
  // single/empty/digit decode looks at the settled registered mask.
  for (genvar g = 0; g < c_CELLS; g++) begin : g_cell
    logic [8:0] w_bits;
    logic [3:0] w_zeros;
    logic [3:0] w_digit;

    assign w_bits         = r_mask[g*9 +: 9];
    assign w_cell_full[g] = &i_stg_mask_in[g*9 +: 9];

    always_comb begin
      w_zeros = 4'd0;
      w_digit = 4'd0;
      for (int v = 0; v < 9; v++) begin
        if (!w_bits[v]) begin
          w_zeros = w_zeros + 4'd1;
          w_digit = 4'(v + 1);
        end
      end
    end

    assign w_cell_single[g]  = (w_zeros == 4'd1);
    assign w_cell_empty[g]   = (w_zeros == 4'd0);
    assign w_grid[g*4 +: 4]  = w_cell_single[g] ? w_digit : 4'd0;
  end

  // Masks only ever gain bits, so full-width equality means the chain
  // found nothing new this pass.
  assign w_fixed = (i_stg_mask_in == r_mask);
  assign w_bad   = |w_cell_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_mask       <= '0;
      r_iter_cnt   <= '0;
      r_solved     <= 1'b0;
      r_contradict <= 1'b0;
      r_timeout    <= 1'b0;
      r_iter_count <= '0;
      r_grid       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_in_valid) begin
            r_mask       <= i_mask_in;
            r_iter_cnt   <= '0;
            r_solved     <= 1'b0;
            r_contradict <= 1'b0;
            r_timeout    <= 1'b0;
            r_iter_count <= '0;
            r_grid       <= '0;
            r_state      <= c_ITER;
          end
        end
        c_ITER: begin
          r_mask     <= i_stg_mask_in;
          r_iter_cnt <= r_iter_cnt + c_ITER_ONE;
          if (w_fixed || w_bad || (r_iter_cnt == c_LAST_ITER)) begin
            r_timeout <= !w_fixed && !w_bad;
            r_state   <= c_CHECK;
          end
        end
        c_CHECK: begin
          r_solved     <= &w_cell_single;
          r_contradict <= |w_cell_empty;
          r_grid       <= w_grid;
          r_iter_count <= r_iter_cnt;
          r_state      <= c_DONE;
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready     = (r_state == c_IDLE);
  assign o_done         = (r_state == c_DONE);
  assign o_stg_mask_out = r_mask;
  assign o_solved       = r_solved;
  assign o_contradict   = r_contradict;
  assign o_timeout      = r_timeout;
  assign o_iter_count   = r_iter_count;
  assign o_grid         = r_grid;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_mask_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sudoku_mask_iter
//  Purpose  : Self-checking bench for sudoku_mask_iter. Models the
//             elimination chain in behavioural code and compares the DUT
//             against a reference that iterates that model directly.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sudoku_mask_iter;

  localparam int P_MAX      = 4;
  localparam int MODE_ELIM  = 0;   // naked-single elimination over peers
  localparam int MODE_CREEP = 1;   // one new exclusion per pass

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [728:0] mask_in;
  logic [728:0] stg_out;
  logic [728:0] stg_in;
  logic         done;
  logic         solved;
  logic         contradict;
  logic         timeout;
  logic [6:0]   iter_count;
  logic [323:0] grid;

  int chain_mode;
  int n_checks;
  int n_fail;

  sudoku_mask_iter #(.MAX_ITER(P_MAX), .ITER_W(7)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_mask_in      (mask_in),
    .o_stg_mask_out (stg_out),
    .i_stg_mask_in  (stg_in),
    .o_done         (done),
    .o_solved       (solved),
    .o_contradict   (contradict),
    .o_timeout      (timeout),
    .o_iter_count   (iter_count),
    .o_grid         (grid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int zeros(input logic [728:0] m, input int c);
    int n = 0;
    for (int v = 0; v < 9; v++) if (!m[c*9 + v]) n++;
    return n;
  endfunction

  function automatic int first_zero(input logic [728:0] m, input int c);
    for (int v = 0; v < 9; v++) if (!m[c*9 + v]) return v;
    return -1;
  endfunction

  function automatic bit peers(input int a, input int b);
    int ax = a / 9, ay = a % 9, bx = b / 9, by = b % 9;
    return (a != b) && ((ax == bx) || (ay == by) ||
                        ((ax / 3 == bx / 3) && (ay / 3 == by / 3)));
  endfunction

  // Environment model of the elimination chain.
  function automatic logic [728:0] chain(input logic [728:0] m, input int mode);
    logic [728:0] r = m;
    if (mode == MODE_ELIM) begin
      for (int c = 0; c < 81; c++) begin
        if (zeros(m, c) == 1) begin
          int d = first_zero(m, c);
          for (int p = 0; p < 81; p++) if (peers(c, p)) r[p*9 + d] = 1'b1;
        end
      end
    end else begin
      for (int c = 0; c < 81; c++) begin
        if (zeros(m, c) >= 2) begin
          r[c*9 + first_zero(m, c)] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  always_comb stg_in = chain(stg_out, chain_mode);

  task automatic check_val(input string tag, input logic [728:0] obs,
                           input logic [728:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: iterate the chain model the way the controller is meant to.
  task automatic ref_run(input logic [728:0] m0, input int mode,
                         output logic [728:0] fm, output int n, output bit to);
    logic [728:0] cur = m0;
    logic [728:0] nx;
    bit fixed = 0;
    bit bad   = 0;
    n = 0;
    for (int k = 0; k < P_MAX; k++) begin
      nx    = chain(cur, mode);
      n++;
      fixed = (nx == cur);
      bad   = 0;
      for (int c = 0; c < 81; c++) if (&nx[c*9 +: 9]) bad = 1;
      cur = nx;
      if (fixed || bad) break;
    end
    to = !fixed && !bad;
    fm = cur;
  endtask

  task automatic decode(input logic [728:0] m, output bit s, output bit c,
                        output logic [323:0] g);
    s = 1; c = 0; g = '0;
    for (int k = 0; k < 81; k++) begin
      int z = zeros(m, k);
      if (z != 1) s = 0;
      if (z == 0) c = 1;
      if (z == 1) g[k*4 +: 4] = 4'(first_zero(m, k) + 1);
    end
  endtask

  // Random valid solution: shifted base pattern, band-local row swaps,
  // digit relabelling.
  function automatic logic [728:0] rand_grid_mask();
    int perm[9];
    int rows[9];
    logic [728:0] m = '1;
    for (int i = 0; i < 9; i++) begin perm[i] = i; rows[i] = i; end
    for (int i = 8; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int b = 0; b < 3; b++) begin
      int a = b*3 + $urandom_range(2, 0);
      int e = b*3 + $urandom_range(2, 0);
      int t = rows[a]; rows[a] = rows[e]; rows[e] = t;
    end
    for (int x = 0; x < 9; x++)
      for (int y = 0; y < 9; y++)
        m[(x*9 + y)*9 + perm[(rows[x]*3 + rows[x]/3 + y) % 9]] = 1'b0;
    return m;
  endfunction

  // One load-to-done transaction. hold>0 keeps in_valid high (with alt)
  // for that many cycles after the accept to show it is ignored.
  task automatic run_job(input logic [728:0] m, input int mode, input int hold,
                         input logic [728:0] alt, input bit chk_clear);
    logic [728:0] fm;
    logic [323:0] e_grid;
    int  n;
    int  cyc;
    int  guard = 0;
    bit  e_to, e_sol, e_con;
    ref_run(m, mode, fm, n, e_to);
    decode(fm, e_sol, e_con, e_grid);
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    check_val("ready_before_load", 729'(in_ready), 729'(1));
    chain_mode = mode;
    mask_in    = m;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (hold > 0) mask_in = alt; else in_valid = 1'b0;
    check_val("loaded_mask", stg_out, m);
    check_val("busy_not_ready", 729'(in_ready), 729'(0));
    if (chk_clear) begin
      check_val("clear_solved", 729'(solved), 729'(0));
      check_val("clear_iter", 729'(iter_count), 729'(0));
      check_val("clear_grid", 729'(grid), 729'(0));
    end
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > hold) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check_val("done_latency", 729'(cyc), 729'(n + 2));
    check_val("iter_count", 729'(iter_count), 729'(n));
    check_val("solved", 729'(solved), 729'(e_sol));
    check_val("contradict", 729'(contradict), 729'(e_con));
    check_val("timeout", 729'(timeout), 729'(e_to));
    check_val("grid", 729'(grid), 729'(e_grid));
    @(posedge clk); #1;
    check_val("done_one_cycle", 729'(done), 729'(0));
    check_val("ready_after_done", 729'(in_ready), 729'(1));
    check_val("hold_solved", 729'(solved), 729'(e_sol));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [728:0] g;
    logic [728:0] m;
    bit saw;
    n_checks   = 0;
    n_fail     = 0;
    chain_mode = MODE_ELIM;
    reset      = 1'b1;
    in_valid   = 1'b0;
    mask_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 729'(in_ready), 729'(1));
    check_val("rst_done", 729'(done), 729'(0));
    check_val("rst_flags", 729'({solved, contradict, timeout}), 729'(0));
    check_val("rst_iter", 729'(iter_count), 729'(0));
    check_val("rst_grid", 729'(grid), 729'(0));
    check_val("rst_mask", stg_out, '0);
    reset = 1'b0;

    // Complete grid, then back-to-back load of the same grid with one cell open.
    g = rand_grid_mask();
    run_job(g, MODE_ELIM, 0, '0, 1'b0);
    m = g;
    m[40*9 +: 9] = '0;
    run_job(m, MODE_ELIM, 0, '0, 1'b1);

    // Contradiction at cell (0,0).
    m = g;
    m[0 +: 9] = '1;
    run_job(m, MODE_ELIM, 0, '0, 1'b0);

    // Never-converging chain: forced stop after P_MAX passes.
    run_job('0, MODE_CREEP, 0, '0, 1'b0);

    // Extra in_valid during iteration must be ignored.
    m = g;
    m[7*9 +: 9] = '0;
    run_job(m, MODE_ELIM, 2, '0, 1'b0);

    // Reset in the second ITER cycle aborts the run.
    chain_mode = MODE_CREEP;
    mask_in    = '0;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_ready", 729'(in_ready), 729'(1));
    check_val("abort_mask", stg_out, '0);
    check_val("abort_flags", 729'({solved, contradict, timeout}), 729'(0));
    check_val("abort_iter", 729'(iter_count), 729'(0));
    saw = 0;
    repeat (10) begin @(posedge clk); #1; if (done) saw = 1; end
    check_val("abort_no_done", 729'(saw), 729'(0));

    // Randomized puzzles: random holes, occasional injected conflicts.
    for (int t = 0; t < 16; t++) begin
      int holes = $urandom_range(25, 0);
      m = rand_grid_mask();
      for (int h = 0; h < holes; h++) m[$urandom_range(80, 0)*9 +: 9] = '0;
      if ($urandom_range(3, 0) == 0) m[$urandom_range(728, 0)] = 1'b1;
      run_job(m, ($urandom_range(3, 0) == 0) ? MODE_CREEP : MODE_ELIM, 0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
